// File: rtl/mem_arbiter_pkg.sv
// Shared memory-subsystem constants and arbiter state/grant encodings.
package mem_arbiter_pkg;

  localparam int MEM_DATA_W    = 16;
  localparam int MEM_ADDR_W    = 8;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    LAST_CPU = 2'd0,
    LAST_DBG = 2'd1,
    DBG_LOCK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter onto one synchronous RAM; round robin with bounded debug burst lock.
// Grant and RAM drive are combinational in the request cycle; read data returns one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W    = MEM_DATA_W,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  gnt_t             gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LAST_DBG;
      beat_cnt   <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= cnt_nxt;
      cpu_rvalid <= (gnt == GNT_CPU) && !cpu_we;
      dbg_rvalid <= (gnt == GNT_DBG) && !dbg_we;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    case (gnt)
      GNT_CPU: begin
        state_nxt = LAST_CPU;
        cnt_nxt   = '0;
      end
      GNT_DBG: begin
        if (dbg_lock) begin
          state_nxt = DBG_LOCK;
          if (state != DBG_LOCK)
            cnt_nxt = CNT_W'(1);
          else if (beat_cnt != CNT_MAX)
            cnt_nxt = beat_cnt + CNT_W'(1);
        end else begin
          state_nxt = LAST_DBG;
          cnt_nxt   = '0;
        end
      end
      default: begin
        // An idle cycle ends any burst.
        if (state == DBG_LOCK) begin
          state_nxt = LAST_DBG;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      case (state)
        LAST_CPU: begin
          if (dbg_req)      gnt = GNT_DBG;
          else if (cpu_req) gnt = GNT_CPU;
        end
        DBG_LOCK: begin
          if (dbg_req && dbg_lock)
            gnt = (beat_cnt < CNT_MAX || !cpu_req) ? GNT_DBG : GNT_CPU;
          else if (cpu_req) gnt = GNT_CPU;
          else if (dbg_req) gnt = GNT_DBG;
        end
        default: begin
          if (cpu_req)      gnt = GNT_CPU;
          else if (dbg_req) gnt = GNT_DBG;
        end
      endcase
    end
    cpu_ack   = (gnt == GNT_CPU);
    dbg_ack   = (gnt == GNT_DBG);
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_ack) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dbg_ack) begin
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        cpu_ack, cpu_rvalid, dbg_ack, dbg_rvalid, ram_we;
  logic [15:0] cpu_rdata, dbg_rdata, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [7:0]  ram_addr;
  logic [15:0] mem [256];

  int total = 0;
  int bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic rst, cr, cw; logic [7:0] ca; logic [15:0] cd;
    logic dr, dw, dl;  logic [7:0] da; logic [15:0] dd;
    logic ecack, edack, ecrv; logic [15:0] ecrd;
    logic edrv; logic [15:0] edrd;
    logic erwe; logic [7:0] eraddr; logic [15:0] erwd;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(
    input logic r, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
    input logic dr, dw, dl, input logic [7:0] da, input logic [15:0] dd,
    input logic ecack, edack, ecrv, input logic [15:0] ecrd,
    input logic edrv, input logic [15:0] edrd,
    input logic erwe, input logic [7:0] eraddr, input logic [15:0] erwd);
    vec_t v;
    v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
    v.ecack = ecack; v.edack = edack; v.ecrv = ecrv; v.ecrd = ecrd;
    v.edrv = edrv; v.edrd = edrd; v.erwe = erwe; v.eraddr = eraddr; v.erwd = erwd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; checks follow 2 time units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic cr, input logic dr, input logic dl);
    cpu_req = cr; cpu_we = 1'b0; cpu_addr = 8'd10;
    dbg_req = dr; dbg_we = 1'b0; dbg_lock = dl; dbg_addr = 8'd20;
  endtask

  task automatic chk_gnt(input string name, input logic ec, input logic ed);
    #2;
    chk(name, {30'd0, cpu_ack, dbg_ack}, {30'd0, ec, ed});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 1);
    mem[3] = 16'd1125;

    //             rst cr cw ca  cd  dr dw dl da  dd    cack dack crv crd   drv drd  rwe raddr rwd
    vecs[0]  = mk(0, 1, 0, 3,  0, 1, 0, 0, 20, 0,    0, 0, 0, 0,    0, 0,   0, 0,  0);
    vecs[1]  = mk(1, 1, 0, 3,  0, 0, 0, 0, 0,  0,    1, 0, 0, 0,    0, 0,   0, 3,  0);
    vecs[2]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  0,    0, 0, 1, 1125, 0, 0,   0, 0,  0);
    vecs[3]  = mk(1, 0, 0, 0,  0, 1, 1, 0, 5,  115,  0, 1, 0, 0,    0, 0,   1, 5,  115);
    vecs[4]  = mk(1, 1, 0, 5,  0, 0, 0, 0, 0,  0,    1, 0, 0, 0,    0, 0,   0, 5,  0);
    vecs[5]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  0,    0, 0, 1, 115,  0, 0,   0, 0,  0);
    vecs[6]  = mk(0, 1, 0, 10, 0, 1, 0, 0, 20, 0,    0, 0, 0, 0,    0, 0,   0, 0,  0);
    vecs[7]  = mk(1, 1, 0, 10, 0, 1, 0, 0, 20, 0,    1, 0, 0, 0,    0, 0,   0, 10, 0);
    vecs[8]  = mk(1, 1, 0, 10, 0, 1, 0, 0, 20, 0,    0, 1, 1, 71,   0, 0,   0, 20, 0);
    vecs[9]  = mk(1, 1, 0, 10, 0, 1, 0, 0, 20, 0,    1, 0, 0, 0,    1, 141, 0, 10, 0);
    vecs[10] = mk(1, 1, 0, 10, 0, 1, 0, 0, 20, 0,    0, 1, 1, 71,   0, 0,   0, 20, 0);
    vecs[11] = mk(1, 0, 0, 0,  0, 1, 0, 0, 7,  0,    0, 1, 0, 0,    1, 141, 0, 7,  0);
    vecs[12] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  0,    0, 0, 0, 0,    1, 50,  0, 0,  0);

    repeat (2) next_cycle();

    for (int i = 0; i < 13; i++) begin
      next_cycle();
      rst = vecs[i].rst;
      cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      dbg_req = vecs[i].dr; dbg_we = vecs[i].dw; dbg_lock = vecs[i].dl;
      dbg_addr = vecs[i].da; dbg_wdata = vecs[i].dd;
      #2;
      chk($sformatf("v%0d cpu_ack", i), int'(cpu_ack), int'(vecs[i].ecack));
      chk($sformatf("v%0d dbg_ack", i), int'(dbg_ack), int'(vecs[i].edack));
      chk($sformatf("v%0d cpu_rvalid", i), int'(cpu_rvalid), int'(vecs[i].ecrv));
      chk($sformatf("v%0d cpu_rdata", i), int'(cpu_rdata), int'(vecs[i].ecrd));
      chk($sformatf("v%0d dbg_rvalid", i), int'(dbg_rvalid), int'(vecs[i].edrv));
      chk($sformatf("v%0d dbg_rdata", i), int'(dbg_rdata), int'(vecs[i].edrd));
      chk($sformatf("v%0d ram_we", i), int'(ram_we), int'(vecs[i].erwe));
      chk($sformatf("v%0d ram_addr", i), int'(ram_addr), int'(vecs[i].eraddr));
      chk($sformatf("v%0d ram_wdata", i), int'(ram_wdata), int'(vecs[i].erwd));
    end

    // Debug read granted, then reset sampled at the very next edge.
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = 8'd9;
    chk_gnt("rst_dbg_grant", 1'b0, 1'b1);
    rst = 1'b0;
    next_cycle();
    set_req(1'b1, 1'b1, 1'b0);
    #2;
    chk("rst_no_dbg_rvalid", int'(dbg_rvalid), 0);
    chk("rst_acks", {30'd0, cpu_ack, dbg_ack}, 0);
    chk("rst_ram_we", int'(ram_we), 0);
    next_cycle();
    rst = 1'b1;
    chk_gnt("rst_first_tie_cpu", 1'b1, 1'b0);

    // Locked burst against a waiting CPU: 8 debug beats then the CPU.
    next_cycle();
    set_req(1'b1, 1'b1, 1'b1);
    chk_gnt("lock_beat", 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      chk_gnt($sformatf("lock_beat%0d", i), 1'b0, 1'b1);
    end
    next_cycle();
    chk_gnt("lock_cpu_after_8", 1'b1, 1'b0);
    next_cycle();
    set_req(1'b1, 1'b1, 1'b0);
    chk_gnt("rr_resume_dbg", 1'b0, 1'b1);
    next_cycle();
    chk_gnt("rr_resume_cpu", 1'b1, 1'b0);
    next_cycle();
    chk_gnt("rr_resume_dbg2", 1'b0, 1'b1);

    // Lock dropped after 3 beats while the CPU is requesting.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_req(1'b0, 1'b1, 1'b1);
      chk_gnt($sformatf("short_lock%0d", i), 1'b0, 1'b1);
    end
    next_cycle();
    set_req(1'b1, 1'b1, 1'b0);
    chk_gnt("unlock_cpu", 1'b1, 1'b0);
    next_cycle();
    chk("unlock_beat_cnt", int'(dut.beat_cnt), 0);
    chk_gnt("unlock_then_dbg", 1'b0, 1'b1);

    // Long burst with an idle CPU: counter saturates, CPU wins at once.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_req(1'b0, 1'b1, 1'b1);
      chk_gnt($sformatf("sat_beat%0d", i), 1'b0, 1'b1);
    end
    next_cycle();
    chk("sat_beat_cnt", int'(dut.beat_cnt), 8);
    set_req(1'b1, 1'b1, 1'b1);
    chk_gnt("sat_cpu_wins", 1'b1, 1'b0);
    next_cycle();
    set_req(1'b0, 1'b0, 1'b0);
    chk("sat_cnt_cleared", int'(dut.beat_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
